// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and encodings
// for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;
  localparam int ACC_W = 2 * XLEN;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the
// EX stage (master) and the mult/div unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, in_1, in_2, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in_1, in_2, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add / restoring-divide
// iteration sharing a single 33-bit adder.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic             is_div,
  output logic [ACC_W-1:0] acc_nxt
);

  logic [WIDTH:0] a;
  logic [WIDTH:0] b;
  logic [WIDTH:0] s;

  always_comb begin
    // divide looks at the remainder already shifted left by one
    a = is_div ? acc[ACC_W-2:WIDTH-1]
               : {1'b0, acc[ACC_W-1:WIDTH]};
    b = {1'b0, opnd};
    s = is_div ? a - b : a + b;
    acc_nxt = {acc[ACC_W-2:0], 1'b0};
    if (is_div) begin
      if (!s[WIDTH])
        acc_nxt = {s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else if (acc[0]) begin
      acc_nxt = {s, acc[WIDTH-1:1]};
    end else begin
      acc_nxt = {a, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/DIV with HI/LO,
// sign-magnitude core plus final sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [WIDTH-1:0] opnd;
  logic             div_q;
  logic             sgn_q;
  logic             sgn_r;
  logic             dz;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic             is_mul;
  logic             is_div;
  logic             is_sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    is_sgn = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_mag  = (is_sgn && bus.in_1[WIDTH-1]) ? -bus.in_1 : bus.in_1;
    b_mag  = (is_sgn && bus.in_2[WIDTH-1]) ? -bus.in_2 : bus.in_2;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .opnd    (opnd),
    .is_div  (div_q),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      div_q  <= 1'b0;
      sgn_q  <= 1'b0;
      sgn_r  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            unique case (1'b1)
              is_mul, is_div: begin
                acc   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                opnd  <= is_div ? b_mag : a_mag;
                div_q <= is_div;
                sgn_q <= is_sgn & (bus.in_1[WIDTH-1] ^ bus.in_2[WIDTH-1]);
                sgn_r <= is_sgn & bus.in_1[WIDTH-1];
                dz    <= is_div && (bus.in_2 == '0);
                cnt   <= '0;
                state <= S_CALC;
              end
              (bus.op == OP_MTHI): hi_q <= bus.in_1;
              (bus.op == OP_MTLO): lo_q <= bus.in_1;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1))
              state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (div_q) begin
              // remainder magnitude equals |in_1| on divide-by-zero
              hi_q <= sgn_r ? -acc[ACC_W-1:WIDTH] : acc[ACC_W-1:WIDTH];
              lo_q <= dz ? '1 : (sgn_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            end else begin
              {hi_q, lo_q} <= sgn_q ? -acc : acc;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline. It sits beside the single-cycle ALU in EX and handles MULT/MULTU/DIV/DIVU over multiple cycles, plus MTHI/MTLO writes. It asserts `busy` so the hazard unit can stall any dependent MFHI/MFLO or any new mult/div. It computes one bit per cycle with a shift-add multiplier and a restoring divider, and applies sign correction at the end.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is verified.
- `clk` input 1 system clock; all state changes on the rising edge.
- `rst_n` input 1 asynchronous, active-low reset.
- `start` input 1 request qualifier; sampled only in IDLE.
- `op` input 3 operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op).
- `in_1` input WIDTH rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `in_2` input WIDTH rt operand: multiplier or divisor.
- `flush` input 1 synchronous abort of an in-flight operation.
- `busy` output 1 high while state is not IDLE; combinational from the state register.
- `done` output 1 one-cycle pulse; HI/LO hold the new result in that cycle.
- `hi` output WIDTH HI register.
- `lo` output WIDTH LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1 and op 0-3:
  - latch |in_1| and |in_2| (magnitudes for signed ops, raw values for unsigned);
  - latch the result signs: product/quotient sign = in_1[31]^in_2[31], remainder sign = in_1[31];
  - clear the accumulator, count=0, go to CALC.
- IDLE with `start`=1 and op 4/5: write in_1 into HI (4) or LO (5) at that edge. No state change, no `done`.
- Reserved ops and `start`=0 do nothing.
- CALC, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit accumulator (33-bit sum, carry kept), then shift right 1.
- CALC, divide: each cycle, shift the {remainder, quotient} pair left 1. Trial-subtract the divisor (33-bit); if non-negative, keep the difference and set quotient bit 1.
- CALC runs for exactly 32 cycles; count 31 goes to FIX.
- FIX, multiply: negate the 64-bit product if its sign bit is set, then write {hi,lo}.
- FIX, divide: lo = quotient, negated if the quotient sign is set; hi = remainder, negated if the remainder sign is set.
- FIX then sets `done` for the next cycle and returns to IDLE.
- Divide by zero (in_2==0, signed or unsigned): keep the fixed latency. Result is hi=in_1 as originally supplied, lo=32'hFFFFFFFF.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This falls out naturally from the magnitude arithmetic with 32-bit wrap.
- `start` while busy is ignored; the hazard unit must hold the instruction.
- `flush`:
  - In CALC or FIX: return to IDLE at the next edge; HI/LO unchanged; no `done`.
  - In IDLE: `flush` overrides `start`, so nothing is accepted or written.
- Reset: state=IDLE, hi=0, lo=0, `done`=0, `busy`=0, all internal registers 0. Reset during CALC discards the operation.

## Timing
- Accept edge E0; CALC during edges E1..E32; FIX at E33.
- HI/LO update at E33, and `done`=1 for the cycle following E33.
- `busy`=1 from after E0 through E33 (33 cycles); `busy`=0 in the `done` cycle.
- A new `start` is accepted in the `done` cycle (back-to-back throughput: 34 cycles per op).
- MTHI/MTLO: one-cycle latency; the new value is visible after the accepting edge.
- `hi`/`lo` are register outputs and never change outside accept (MTHI/MTLO) or FIX edges.

## Structure
- Package `muldiv_pkg`:
  - op encodings (OP_MULT … OP_MTLO);
  - state enum (S_IDLE, S_CALC, S_FIX);
  - WIDTH-derived constants (count width 5, accumulator width 2*WIDTH).
- One sub-module, `muldiv_step`: combinational single-iteration datapath. It takes the accumulator, operand and mode, and returns the next accumulator using a shared 33-bit adder/subtractor.
- `muldiv_unit` keeps the FSM, counter, sign flags, and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles: hi=0xFFFFFFFE, lo=0x00000001, one `done` pulse, `busy` high exactly 33 cycles.
- MULT −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV −7 / 2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU 100 / 0 → hi=100, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → both visible one cycle later, `busy` never high. A `start` asserted at cycle 10 of a DIVU is ignored and HI/LO match the DIVU result.
- DIVU 50/7 started; `flush` at cycle 15 → `busy` drops next cycle, no `done`, HI/LO retain prior values. A new MULTU 6×7 then yields lo=42, hi=0.
- Assert `rst_n`=0 mid-CALC → `busy`, `done`, hi, lo all 0 immediately. After release, MULTU 2×3 gives lo=6.
